// File: rtl/elixirchip_es1_spu_sra_arbiter.sv
// Round-robin scheduler sharing one fixed-latency arithmetic-right-shift SPU operator
// among NUM_REQ requesters, with an ID tag pipeline that follows each issue to its result.
module elixirchip_es1_spu_sra_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_BITS  = 8,
    parameter int SHIFT_BITS = $clog2(DATA_BITS),
    parameter int LATENCY    = 1,
    parameter int ID_BITS    = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          cke,
    input  logic [NUM_REQ-1:0]            s_valid,
    output logic [NUM_REQ-1:0]            s_ready,
    input  logic [NUM_REQ*DATA_BITS-1:0]  s_data,
    input  logic [NUM_REQ*SHIFT_BITS-1:0] s_shift,
    output logic [DATA_BITS-1:0]          op_data,
    output logic [SHIFT_BITS-1:0]         op_shift,
    output logic                          op_clear,
    output logic                          op_valid,
    input  logic [DATA_BITS-1:0]          op_result,
    output logic                          m_valid,
    output logic [ID_BITS-1:0]            m_id,
    output logic [DATA_BITS-1:0]          m_data
);

    logic [ID_BITS-1:0] ptr;
    logic [ID_BITS-1:0] winner;
    logic               found;
    logic [NUM_REQ-1:0] grant;
    logic               issue_en;
    logic               transfer;
    logic               tag_valid;
    logic [ID_BITS-1:0] tag_id;

    function automatic logic [ID_BITS-1:0] rr_index(input logic [ID_BITS-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return ID_BITS'(sum);
    endfunction

    // Requests are also blocked during reset so nothing is accepted while state is cleared.
    assign issue_en = cke & reset_n;

    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && s_valid[rr_index(ptr, k)]) begin
                found  = 1'b1;
                winner = rr_index(ptr, k);
            end
        end
        if (found) begin
            grant[winner] = 1'b1;
        end
    end

    assign s_ready  = grant & {NUM_REQ{issue_en}};
    assign transfer = issue_en & found;
    assign op_valid = transfer;
    assign op_clear = ~transfer;

    always_comb begin
        op_data  = '0;
        op_shift = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (s_ready[i]) begin
                op_data  = s_data[i*DATA_BITS +: DATA_BITS];
                op_shift = s_shift[i*SHIFT_BITS +: SHIFT_BITS];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (transfer) begin
            ptr <= (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
        end
    end

    // Tag stages mirror the operator's internal pipeline so tag and data emerge together.
    generate
        if (LATENCY == 0) begin : g_no_pipe
            assign tag_valid = transfer;
            assign tag_id    = winner;
        end else begin : g_pipe
            logic [LATENCY-1:0] pipe_valid;
            logic [ID_BITS-1:0] pipe_id [LATENCY];

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    pipe_valid <= '0;
                    for (int i = 0; i < LATENCY; i++) begin
                        pipe_id[i] <= '0;
                    end
                end else if (cke) begin
                    pipe_valid[0] <= transfer;
                    pipe_id[0]    <= winner;
                    for (int i = 1; i < LATENCY; i++) begin
                        pipe_valid[i] <= pipe_valid[i-1];
                        pipe_id[i]    <= pipe_id[i-1];
                    end
                end
            end

            assign tag_valid = pipe_valid[LATENCY-1];
            assign tag_id    = pipe_id[LATENCY-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_valid <= 1'b0;
            m_id    <= '0;
            m_data  <= '0;
        end else if (cke) begin
            m_valid <= tag_valid;
            if (tag_valid) begin
                m_id   <= tag_id;
                m_data <= op_result;
            end
        end
    end

endmodule

// File: tb/tb_elixirchip_es1_spu_sra_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized traffic,
// all outputs compared every cycle against a queue-based model of the scheduler.
module tb_elixirchip_es1_spu_sra_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int DATA_BITS  = 8;
    localparam int SHIFT_BITS = 3;
    localparam int LATENCY    = 2;
    localparam int ID_BITS    = 2;

    logic                          clk     = 1'b0;
    logic                          reset_n = 1'b0;
    logic                          cke     = 1'b0;
    logic [NUM_REQ-1:0]            s_valid = '0;
    logic [NUM_REQ-1:0]            s_ready;
    logic [NUM_REQ*DATA_BITS-1:0]  s_data  = '0;
    logic [NUM_REQ*SHIFT_BITS-1:0] s_shift = '0;
    logic [DATA_BITS-1:0]          op_data;
    logic [SHIFT_BITS-1:0]         op_shift;
    logic                          op_clear;
    logic                          op_valid;
    logic [DATA_BITS-1:0]          op_result;
    logic                          m_valid;
    logic [ID_BITS-1:0]            m_id;
    logic [DATA_BITS-1:0]          m_data;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] sign_data  [4] = '{8'h7F, 8'h81, 8'hFF, 8'h40};
    logic [2:0] sign_shift [4] = '{3'd7, 3'd1, 3'd7, 3'd0};
    logic [7:0] sign_res   [4] = '{8'h00, 8'hC0, 8'hFF, 8'h40};

    always #5 clk = ~clk;

    elixirchip_es1_spu_sra_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_BITS(DATA_BITS), .SHIFT_BITS(SHIFT_BITS),
        .LATENCY(LATENCY), .ID_BITS(ID_BITS)
    ) dut (
        .clk(clk), .reset_n(reset_n), .cke(cke),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_shift(s_shift),
        .op_data(op_data), .op_shift(op_shift), .op_clear(op_clear), .op_valid(op_valid),
        .op_result(op_result),
        .m_valid(m_valid), .m_id(m_id), .m_data(m_data)
    );

    // Stand-in for the shared shift operator: two enabled stages, zero when cleared.
    logic [7:0] op_stage0 = '0;
    logic [7:0] op_stage1 = '0;
    always @(posedge clk) begin
        if (cke) begin
            op_stage0 <= op_clear ? 8'h00 : 8'($signed(op_data) >>> op_shift);
            op_stage1 <= op_stage0;
        end
    end
    assign op_result = op_stage1;

    // Reference model: in-flight operations kept as a queue aged in enabled cycles.
    typedef struct {
        int         age;
        int         id;
        logic [7:0] data;
    } flight_t;

    flight_t    in_flight[$];
    int         model_ptr   = 0;
    logic       exp_m_valid = 1'b0;
    int         exp_m_id    = 0;
    logic [7:0] exp_m_data  = 8'h00;

    function automatic int pick_winner(input logic [3:0] valid, input int base);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (valid[(base + k) % NUM_REQ]) return (base + k) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    initial forever begin
        int      w;
        flight_t f;
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            in_flight.delete();
            model_ptr   = 0;
            exp_m_valid = 1'b0;
            exp_m_id    = 0;
            exp_m_data  = 8'h00;
        end else if (cke) begin
            foreach (in_flight[i]) in_flight[i].age++;
            w = pick_winner(s_valid, model_ptr);
            if (w >= 0) begin
                f.age  = 0;
                f.id   = w;
                f.data = 8'($signed(s_data[w*8 +: 8]) >>> s_shift[w*3 +: 3]);
                in_flight.push_back(f);
                model_ptr = (w + 1) % NUM_REQ;
            end
            if (in_flight.size() > 0 && in_flight[0].age == LATENCY) begin
                f           = in_flight.pop_front();
                exp_m_valid = 1'b1;
                exp_m_id    = f.id;
                exp_m_data  = f.data;
            end else begin
                exp_m_valid = 1'b0;
            end
        end
    end

    // Every cycle: grant, operator drive and result outputs against the model.
    always @(negedge clk) begin
        int         w;
        logic [3:0] er;
        logic [7:0] ed;
        logic [2:0] es;
        w  = (reset_n && cke) ? pick_winner(s_valid, model_ptr) : -1;
        er = '0;
        ed = '0;
        es = '0;
        if (w >= 0) begin
            er[w] = 1'b1;
            ed    = s_data[w*8 +: 8];
            es    = s_shift[w*3 +: 3];
        end
        check_output("model_s_ready", s_ready, er);
        check_output("model_op", {op_valid, op_clear, op_shift, op_data}, {w >= 0, w < 0, es, ed});
        check_output("model_m_out", {m_valid, m_id, m_data}, {exp_m_valid, 2'(exp_m_id), exp_m_data});
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic cke_v, input logic [3:0] valid_v);
        cke     = cke_v;
        s_valid = valid_v;
    endtask

    task automatic set_req(input int idx, input logic [7:0] d, input logic [2:0] sh);
        s_data[idx*8 +: 8]  = d;
        s_shift[idx*3 +: 3] = sh;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        apply_stimulus(1'b1, 4'b0000);
        next_cycle();
        next_cycle();
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        cke     = 1'b1;
        next_cycle();
        @(negedge clk);
        check_output("reset_state", {s_ready, m_valid, m_id, m_data}, '0);
        next_cycle();
        reset_n = 1'b1;

        // Single request from req1: 0x80 >>> 3 = 0xF0 three cycles later.
        set_req(1, 8'h80, 3'd3);
        apply_stimulus(1'b1, 4'b0010);
        @(negedge clk);
        check_output("single_ready", s_ready, 4'b0010);
        next_cycle();
        apply_stimulus(1'b1, 4'b0000);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 3) check_output("single_result", {m_valid, m_id, m_data}, {1'b1, 2'd1, 8'hF0});
            else        check_output("single_idle", m_valid, 1'b0);
            next_cycle();
        end

        // Round-robin rotation with all four requesters holding valid.
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 8'(i * 16 + 1), 3'(i));
        apply_stimulus(1'b1, 4'b1111);
        for (int c = 0; c < 11; c++) begin
            if (c == 8) apply_stimulus(1'b1, 4'b0000);
            @(negedge clk);
            if (c < 8)  check_output("rr_ready", s_ready, 32'(1 << (c % 4)));
            if (c >= 3) check_output("rr_result", {m_valid, m_id}, {1'b1, 2'((c - 3) % 4)});
            next_cycle();
        end

        // Pointer wrap: move ptr to 3, then req3 and req0 compete.
        do_reset();
        set_req(2, 8'h11, 3'd0);
        apply_stimulus(1'b1, 4'b0100);
        @(negedge clk);
        check_output("wrap_setup", s_ready, 4'b0100);
        next_cycle();
        set_req(3, 8'hA5, 3'd1);
        set_req(0, 8'h5A, 3'd2);
        apply_stimulus(1'b1, 4'b1001);
        @(negedge clk);
        check_output("wrap_first", s_ready, 4'b1000);
        next_cycle();
        @(negedge clk);
        check_output("wrap_second", s_ready, 4'b0001);
        next_cycle();
        @(negedge clk);
        check_output("wrap_ptr_one", s_ready, 4'b1000);
        next_cycle();
        apply_stimulus(1'b1, 4'b0000);
        for (int c = 0; c < 4; c++) next_cycle();

        // Sign and boundary shifts, back to back from req0.
        do_reset();
        for (int c = 0; c < 7; c++) begin
            if (c < 4) begin
                set_req(0, sign_data[c], sign_shift[c]);
                apply_stimulus(1'b1, 4'b0001);
            end else begin
                apply_stimulus(1'b1, 4'b0000);
            end
            @(negedge clk);
            if (c >= 3) check_output("sign_result", {m_valid, m_data}, {1'b1, sign_res[c - 3]});
            next_cycle();
        end

        // Clock-enable stall of three cycles right after an issue.
        do_reset();
        set_req(2, 8'h90, 3'd2);
        set_req(0, 8'h33, 3'd1);
        for (int c = 0; c < 8; c++) begin
            if (c == 0)      apply_stimulus(1'b1, 4'b0100);
            else if (c <= 3) apply_stimulus(1'b0, 4'b0101);
            else             apply_stimulus(1'b1, 4'b0000);
            @(negedge clk);
            if (c >= 1 && c <= 3) check_output("stall_ready", s_ready, 4'b0000);
            if (c == 6) check_output("stall_result", {m_valid, m_id, m_data}, {1'b1, 2'd2, 8'hE4});
            else        check_output("stall_idle", m_valid, 1'b0);
            next_cycle();
        end

        // Reset while two results are in flight.
        do_reset();
        set_req(0, 8'h20, 3'd1);
        set_req(1, 8'h44, 3'd2);
        set_req(3, 8'h88, 3'd1);
        for (int c = 0; c < 8; c++) begin
            reset_n = (c != 2);
            if (c == 0)      apply_stimulus(1'b1, 4'b0011);
            else if (c == 1) apply_stimulus(1'b1, 4'b0010);
            else if (c <= 3) apply_stimulus(1'b1, 4'b1010);
            else             apply_stimulus(1'b1, 4'b0000);
            @(negedge clk);
            if (c == 2) check_output("reset_clears", {s_ready, op_valid, op_clear, m_valid, m_id, m_data},
                                     {4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00});
            if (c == 3) check_output("reset_next_grant", s_ready, 4'b0010);
            if (c >= 3 && c <= 5) check_output("reset_no_stale", m_valid, 1'b0);
            if (c == 6) check_output("reset_new_result", {m_valid, m_id, m_data}, {1'b1, 2'd1, 8'h11});
            next_cycle();
        end

        // Randomized traffic with occasional stalls and resets.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            reset_n = ($urandom_range(0, 199) != 0);
            for (int i = 0; i < 4; i++) set_req(i, 8'($urandom), 3'($urandom));
            apply_stimulus($urandom_range(0, 9) != 0, 4'($urandom));
            next_cycle();
        end
        reset_n = 1'b1;
        apply_stimulus(1'b1, 4'b0000);
        for (int c = 0; c < 5; c++) next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
